// File: rtl/sa_ram_rd_stream_128x512.sv
// Streams a burst of rows from a 128x512 synchronous-read RAM onto a valid/ready port.
// Define SA_RAM_RD_STREAM_WRAP_EN to let a burst wrap past row 127 instead of rejecting it.
module sa_ram_rd_stream_128x512 #(
   parameter int AW = 7,
   parameter int DW = 512
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [7:0]    len,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] ram_ra,
   output logic          ram_re,
   input  logic [DW-1:0] ram_dout,
   output logic [31:0]   pwrbus_ram_pd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] ra_q, ra_d;
   logic          re_q, re_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [7:0]    issue_left_q, issue_left_d;
   logic [7:0]    rows_left_q, rows_left_d;
   logic          rv_q, rv_d;
   logic [1:0]    fifo_cnt_q, fifo_cnt_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] fifo_mem_q [2];

   logic fifo_empty;
   logic hs;
   logic push;
   logic pop;
   logic room;
   logic len_ok;

`ifdef SA_RAM_RD_STREAM_WRAP_EN
   assign len_ok = (len <= 8'd128);
`else
   assign len_ok = ((9'(base) + 9'(len)) <= 9'd128);
`endif

   // rv_q marks the single cycle in which ram_dout carries a freshly read row;
   // it is either handed straight out or parked in the 2-entry buffer.
   always_comb begin
      fifo_empty = (fifo_cnt_q == 2'd0);
      out_valid  = !fifo_empty || rv_q;
      if (!fifo_empty) begin
         out_data = fifo_mem_q[rd_ptr_q];
      end else if (rv_q) begin
         out_data = ram_dout;
      end else begin
         out_data = '0;
      end
      out_last   = out_valid && (rows_left_q == 8'd1);
      hs         = out_valid && out_ready;
      pop        = hs && !fifo_empty;
      push       = rv_q && !(hs && fifo_empty);
      fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      rv_d       = re_q;
      // Rows committed at the next edge: buffered ones plus the read now in flight.
      room       = (fifo_cnt_d + 2'(re_q)) < 2'd2;
   end

   always_comb begin
      state_d      = state_q;
      ra_d         = ra_q;
      re_d         = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      issue_left_d = issue_left_q;
      rows_left_d  = rows_left_q;
      if (hs) begin
         rows_left_d = rows_left_q - 8'd1;
      end
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len == 8'd0) begin
                  done_d = 1'b1;
               end else if (!len_ok) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  re_d         = 1'b1;
                  ra_d         = base;
                  issue_left_d = len - 8'd1;
                  rows_left_d  = len;
                  state_d      = (len == 8'd1) ? ST_DRAIN : ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (room) begin
               re_d         = 1'b1;
               ra_d         = ra_q + AW'(1);
               issue_left_d = issue_left_q - 8'd1;
               if (issue_left_q == 8'd1) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (hs && (rows_left_q == 8'd1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ra_q         <= '0;
         re_q         <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         issue_left_q <= '0;
         rows_left_q  <= '0;
         rv_q         <= 1'b0;
         fifo_cnt_q   <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ra_q         <= ra_d;
         re_q         <= re_d;
         done_q       <= done_d;
         err_q        <= err_d;
         issue_left_q <= issue_left_d;
         rows_left_q  <= rows_left_d;
         rv_q         <= rv_d;
         fifo_cnt_q   <= fifo_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Buffer storage needs no reset; occupancy is tracked by fifo_cnt_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= ram_dout;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign err           = err_q;
   assign ram_ra        = ra_q;
   assign ram_re        = re_q;
   assign pwrbus_ram_pd = '0;

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (fifo_cnt_q == 2'd2)));
   a_no_read_when_full: assert property (@(posedge clk) disable iff (rst)
      !(re_q && ((fifo_cnt_q + 2'(rv_q)) >= 2'd2)));

endmodule

// File: tb/tb_sa_ram_rd_stream_128x512.sv
// Randomized bench for sa_ram_rd_stream_128x512 against a queue-based row/address model.
// Expectations follow SA_RAM_RD_STREAM_WRAP_EN when it is defined for the build.
module tb_sa_ram_rd_stream_128x512;
   localparam int DW = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [6:0]    base;
   logic [7:0]    len;
   logic          busy;
   logic          done;
   logic          err;
   logic [6:0]    ram_ra;
   logic          ram_re;
   logic [DW-1:0] ram_dout = '0;
   logic [31:0]   pwrbus_ram_pd;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   sa_ram_rd_stream_128x512 #(.AW(7), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
      .busy(busy), .done(done), .err(err),
      .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
      .pwrbus_ram_pd(pwrbus_ram_pd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:127];
   always @(posedge clk) if (ram_re) ram_dout <= mem[ram_ra];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: each accepted burst expects reads of (base+k) mod 128 in order and
   // the same rows delivered in order, the last one flagged.
   int exp_rd_q[$];
   int exp_row_q[$];
   int issued_n = 0;
   int acked_n  = 0;
   int done_n   = 0;
   int err_n    = 0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] data_prev  = '0;
   logic          last_prev  = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         issued_n   = 0;
         acked_n    = 0;
      end else begin
         if (ram_re) begin
            check_eq("re_room", 1'((issued_n - acked_n) < 2), 1'b1);
            if (exp_rd_q.size() == 0) check_eq("re_spurious", ram_re, 1'b0);
            else check_eq("re_addr", ram_ra, exp_rd_q.pop_front());
            issued_n++;
         end
         if (stall_prev) begin
            check_eq("stall_valid", out_valid, 1'b1);
            check_eq("stall_data", out_data, data_prev);
            check_eq("stall_last", out_last, last_prev);
         end
         if (out_valid && out_ready) begin
            if (exp_row_q.size() == 0) begin
               check_eq("row_spurious", out_valid, 1'b0);
            end else begin
               int a;
               a = exp_row_q.pop_front();
               check_eq("row_data", out_data, mem[a]);
               check_eq("row_last", out_last, 1'(exp_row_q.size() == 0));
            end
            acked_n++;
         end
         if (!out_valid) check_eq("last_idle", out_last, 1'b0);
         stall_prev = out_valid && !out_ready;
         data_prev  = out_data;
         last_prev  = out_last;
         if (done) done_n++;
         if (err) err_n++;
      end
   end

   task automatic set_ready(input int mode, input int c);
      case (mode)
         0: out_ready = 1'b1;
         1: out_ready = ((c % 3) == 0);
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   // inj > 0 pulses a rogue start in that cycle of the burst (DUT is busy then).
   task automatic run_burst(input int b, input int l, input int mode, input int inj);
      bit legal;
      int cyc;
      int done0;
      int err0;
      bit exp_err;
`ifdef SA_RAM_RD_STREAM_WRAP_EN
      legal = (l <= 128);
`else
      legal = ((b + l) <= 128);
`endif
      exp_err = (l > 0) && !legal;
      if (legal) begin
         for (int k = 0; k < l; k++) begin
            exp_rd_q.push_back((b + k) % 128);
            exp_row_q.push_back((b + k) % 128);
         end
      end
      done0 = done_n;
      err0  = err_n;
      base  = 7'(b);
      len   = 8'(l);
      start = 1'b1;
      set_ready(mode, 0);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      set_ready(mode, cyc);
      while (!done && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
         set_ready(mode, cyc);
         if (inj > 0 && cyc == inj) begin
            base  = 7'h33;
            len   = 8'd5;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check_eq("done_seen", done, 1'b1);
      check_eq("err_flag", err, exp_err);
      check_eq("busy_at_done", busy, 1'b0);
      if (l == 0 || !legal) check_eq("done_cyc_quick", cyc, 1);
      else if (mode == 0) check_eq("done_cyc", cyc, l + 2);
      check_eq("rows_left", exp_row_q.size(), 0);
      check_eq("reads_left", exp_rd_q.size(), 0);
      @(posedge clk); #1;
      check_eq("done_pulse", done, 1'b0);
      check_eq("err_pulse", err, 1'b0);
      check_eq("done_count", done_n, done0 + 1);
      check_eq("err_count", err_n, err0 + int'(exp_err));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_done"}, done, 1'b0);
      check_eq({tag, "_err"}, err, 1'b0);
      check_eq({tag, "_re"}, ram_re, 1'b0);
      check_eq({tag, "_ra"}, ram_ra, 7'd0);
      check_eq({tag, "_valid"}, out_valid, 1'b0);
      check_eq({tag, "_last"}, out_last, 1'b0);
      check_eq({tag, "_data"}, out_data, '0);
      check_eq({tag, "_pd"}, pwrbus_ram_pd, 32'd0);
   endtask

   task automatic reset_mid_burst();
      int a0;
      int guard;
      int done0;
      for (int k = 0; k < 10; k++) begin
         exp_rd_q.push_back(20 + k);
         exp_row_q.push_back(20 + k);
      end
      done0     = done_n;
      a0        = acked_n;
      base      = 7'd20;
      len       = 8'd10;
      out_ready = 1'b1;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while ((acked_n - a0) < 3 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check_eq("row3_reached", 1'((acked_n - a0) >= 3), 1'b1);
      check_eq("row3_valid", out_valid, 1'b1);
      #1 rst = 1'b1;
      #1 check_all_zero("rst_async");
      exp_rd_q.delete();
      exp_row_q.delete();
      @(posedge clk); #1;
      check_all_zero("rst_held");
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("no_done_after_rst", done_n, done0);
      check_eq("idle_after_rst", busy, 1'b0);
      run_burst(0, 2, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 128; r++) begin
         for (int w = 0; w < DW / 32; w++) mem[r][w*32 +: 32] = $urandom;
      end
      rst       = 1'b1;
      start     = 1'b0;
      base      = '0;
      len       = '0;
      out_ready = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_burst(0, 128, 0, 0);
      run_burst(5, 4, 1, 0);
      run_burst(9, 0, 0, 0);
      run_burst(40, 6, 0, 3);
      run_burst(120, 16, 0, 0);
      run_burst(127, 1, 1, 0);
      run_burst(0, 1, 2, 0);
      run_burst(100, 28, 1, 0);
      reset_mid_burst();

      for (int i = 0; i < 24; i++) begin
         int b;
         int l;
         b = $urandom_range(0, 127);
         l = $urandom_range(0, 128);
         if ($urandom_range(0, 1) == 1 && (b + l) > 128) l = 128 - b;
         run_burst(b, l, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 2 : 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/sa_ram_rd_stream_128x512.md
SA_RAM_RD_STREAM_128X512 -- requirements
Module: sa_ram_rd_stream_128x512

Interface
REQ-001 Parameters (fixed): AW, 7, RAM address width; DW, 512, RAM and stream data width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle request strobe; sampled only in IDLE.
REQ-005 base  input  7  first RAM row of the burst.
REQ-006 len  input  8  burst length in rows, 0..128.
REQ-007 busy  output  1  high while not in IDLE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 err  output  1  one-cycle rejected-request pulse.
REQ-010 ram_ra  output  7  RAM read address.
REQ-011 ram_re  output  1  RAM read enable; RAM captures ra on the edge where re=1.
REQ-012 ram_dout  input  512  RAM read data; valid the cycle after a re=1 edge, held until the next re=1 edge.
REQ-013 pwrbus_ram_pd  output  32  RAM power-down bus, tied to 0.
REQ-014 out_valid, out_ready, out_data[511:0], out_last  output/input/output/output  valid/ready stream of rows; out_last marks the final row.

Function
REQ-015 States: IDLE, RUN, DRAIN.
- IDLE->RUN on start with a legal len>0.
- RUN->DRAIN when the last ram_re is issued.
- DRAIN->IDLE on the out_last handshake.
REQ-016 start when busy=1 has no effect.
REQ-017 start with len=0: done pulse next cycle, err=0, no ram_re, stay IDLE.
REQ-018 Row k (k=0..len-1) reads address base+k; reads are issued in ascending order, one per cycle at most.
REQ-019 The first ram_re is issued the cycle after start; out_valid for row 0 rises the cycle after that ram_re.
REQ-020 Internal 2-entry output buffer.
- ram_re is issued only when (reads in flight + buffered rows) < 2.
- A row is never lost or duplicated under any out_ready pattern.
REQ-021 With out_ready held at 1, rows stream at 1 per cycle; a len-row burst finishes in len+2 cycles from start.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last hold stable.
REQ-023 done pulses the cycle after the out_last handshake; busy falls in that same cycle.
REQ-024 out_last=1 only on row len-1; out_valid=0 in IDLE.
REQ-025 ram_ra holds its last value when ram_re=0.

Reset
REQ-026 While rst is high, regardless of clk: state=IDLE; busy, done, err, ram_re, out_valid and out_last = 0; ram_ra=0; buffer empty; in-flight reads discarded.
REQ-027 Reset asserted mid-burst aborts the burst with no done pulse; the first start after release behaves as from power-up.

Configuration
REQ-028 Macro SA_RAM_RD_STREAM_WRAP_EN.
- Defined: addresses wrap modulo 128, so base+len>128 is legal (base=120, len=16 reads 120..127, then 0..7).
- Undefined: start with base+len>128 pulses err and done together the next cycle, issues no ram_re, and stays IDLE.

Verification
REQ-029 base=0, len=128, out_ready=1:
- Rows 0..127 output in order, out_last on row 127.
- done at cycle 130 after start.
REQ-030 base=5, len=4, out_ready toggling 1,0,0,1,...:
- Rows 5,6,7,8 each output exactly once.
- out_data stable during stalls.
- ram_re never issued when 2 rows are already committed.
REQ-031 len=0: done pulse next cycle, no ram_re. A second start while busy: ignored, burst count unchanged.
REQ-032 base=120, len=16:
- Without the macro: err and done pulse, no reads.
- With the macro: rows 120..127 then 0..7.
REQ-033 rst asserted at row 3 of a len=10 burst: all outputs 0 asynchronously, no done pulse. A new base=0, len=2 burst then completes normally.
